// File: rtl/rr_arb_pkg.sv
// rr_arb_pkg: shared definitions for the eight-requester round-robin arbiter.
//   N_REQ           number of requesters (8)
//   PTR_W           width of the round-robin priority pointer (3)
//   DEF_TIMEOUT_CYC default maximum grant hold time in cycles (16)
//   arb_state_e     arbiter FSM states (IDLE, GRANT)
//   onehot_to_idx   converts a one-hot grant into the owner index
package rr_arb_pkg;

    localparam int N_REQ           = 8;
    localparam int PTR_W           = 3;
    localparam int DEF_TIMEOUT_CYC = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // ORing every set index is exact because the input is one-hot.
    function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [PTR_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) begin
                idx = idx | PTR_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// rr_arbiter8_if: request/grant bundle between the requesters and the arbiter.
//   req[7:0]   request lines, bit i is requester i (level-sensitive)
//   done       current owner releases its grant
//   gnt[7:0]   one-hot grant or all-zero, feeds the 8-to-3 encoder
//   gnt_valid  high while any grant is held
//   timeout    one-cycle pulse when a grant is force-released
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
    import rr_arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             done;
    logic [N_REQ-1:0] gnt;
    logic             gnt_valid;
    logic             timeout;

    modport master (
        output req,
        output done,
        input  gnt,
        input  gnt_valid,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output gnt,
        output gnt_valid,
        output timeout
    );

endinterface

// File: rtl/rr_arbiter8_pick.sv
// rr_pick8: combinational round-robin selector.
//   req[7:0]  request lines
//   ptr[2:0]  index with highest priority; priority falls off circularly
//   pick[7:0] one-hot winner, zero when no request is set
//   any       high when any request is set
// The requests are rotated so ptr lands on bit 0, the lowest set bit is
// isolated, and the result is rotated back into requester positions.
module rr_pick8
    import rr_arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic             any
);

    logic [N_REQ-1:0] req_rot;
    logic [N_REQ-1:0] first_rot;

    always_comb begin
        req_rot = '0;
        for (int i = 0; i < N_REQ; i++) begin
            req_rot[i] = req[PTR_W'(i) + ptr];
        end
    end

    // Two's-complement trick: x & -x keeps only the lowest set bit.
    assign first_rot = req_rot & (~req_rot + N_REQ'(1));

    always_comb begin
        pick = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pick[i] = first_rot[PTR_W'(i) - ptr];
        end
    end

    assign any = |req;

endmodule

// File: rtl/rr_arbiter8.sv
// rr_arbiter8: eight-requester round-robin arbiter with held grants.
//   clk     rising-edge clock
//   rst_n   asynchronous active-low reset
//   bus     rr_arbiter8_if.slave (req, done in; gnt, gnt_valid, timeout out)
// Parameter TIMEOUT_CYC (2..255): maximum grant hold time, only used when
// the macro RR_ARB_TIMEOUT_EN is defined. Without the macro no hold counter
// is built and timeout is constant 0.
// Every release returns through IDLE, which guarantees one all-zero gnt
// cycle between owners.
module rr_arbiter8
    import rr_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_arbiter8_if.slave bus
);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [N_REQ-1:0] pick_gnt;
    logic             pick_any;
    logic             withdrawn;
    logic             expired;

    if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("rr_arbiter8: TIMEOUT_CYC must be within 2..255");
    end

    rr_pick8 u_pick (
        .req  (bus.req),
        .ptr  (ptr_q),
        .pick (pick_gnt),
        .any  (pick_any)
    );

    // Owner's request line dropped while it holds the grant.
    assign withdrawn = (bus.req & gnt_q) == '0;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_d = '0;
                if (pick_any) begin
                    gnt_d   = pick_gnt;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (bus.done || withdrawn || expired) begin
                    gnt_d   = '0;
                    ptr_d   = onehot_to_idx(gnt_q) + PTR_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= |gnt_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q;
    logic       timeout_q;

    assign expired = (state_q == GRANT) && (hold_cnt_q == 8'(TIMEOUT_CYC - 1));

    // Counter reads 0 in the first GRANT cycle; timeout flags only a forced
    // release, so a done or withdrawal on the expiry cycle does not pulse it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            timeout_q <= expired && !bus.done && !withdrawn;
            if (state_q == GRANT) begin
                hold_cnt_q <= hold_cnt_q + 8'd1;
            end else begin
                hold_cnt_q <= '0;
            end
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign expired     = 1'b0;
    assign bus.timeout = 1'b0;
`endif

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb_rr_arbiter8: directed and random checks of rr_arbiter8 against a
// requester-level reference model (owner index, pointer, hold time).
// Built with TIMEOUT_CYC=4; timeout expectations follow RR_ARB_TIMEOUT_EN.
module tb_rr_arbiter8;

    localparam int TO_CYC = 4;

    logic clk = 1'b0;
    logic rst_n;

    rr_arbiter8_if bus ();

    rr_arbiter8 #(.TIMEOUT_CYC(TO_CYC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: who owns the grant, where the scan starts, how long
    // the owner has held it, and whether the last release was forced.
    int m_owner;
    int m_ptr;
    int m_hold;
    bit m_timeout;

    task automatic modelReset();
        m_owner   = -1;
        m_ptr     = 0;
        m_hold    = 0;
        m_timeout = 1'b0;
    endtask

    task automatic modelStep(input logic [7:0] r, input logic d);
        bit rel;
        bit forced;
        rel    = 1'b0;
        forced = 1'b0;
        if (m_owner >= 0) begin
            rel = d || !r[m_owner];
`ifdef RR_ARB_TIMEOUT_EN
            forced = !rel && (m_hold == TO_CYC - 1);
`endif
            if (rel || forced) begin
                m_ptr     = (m_owner + 1) % 8;
                m_owner   = -1;
                m_timeout = forced;
            end else begin
                m_hold    = m_hold + 1;
                m_timeout = 1'b0;
            end
        end else begin
            m_timeout = 1'b0;
            for (int k = 0; k < 8; k++) begin
                if (r[(m_ptr + k) % 8]) begin
                    m_owner = (m_ptr + k) % 8;
                    m_hold  = 0;
                    break;
                end
            end
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [7:0] exp_gnt;
        logic       exp_valid;
        exp_gnt   = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        exp_valid = (m_owner >= 0);
        checks++;
        assert (bus.gnt === exp_gnt) else begin
            errors++;
            $error("[TB] FAIL %s gnt: got %h expected %h", tag, bus.gnt, exp_gnt);
        end
        checks++;
        assert (bus.gnt_valid === exp_valid) else begin
            errors++;
            $error("[TB] FAIL %s gnt_valid: got %b expected %b", tag, bus.gnt_valid, exp_valid);
        end
        checks++;
        assert (bus.timeout === m_timeout) else begin
            errors++;
            $error("[TB] FAIL %s timeout: got %b expected %b", tag, bus.timeout, m_timeout);
        end
    endtask

    task automatic checkGnt(input string tag, input logic [7:0] exp_gnt);
        checks++;
        assert (bus.gnt === exp_gnt) else begin
            errors++;
            $error("[TB] FAIL %s gnt: got %h expected %h", tag, bus.gnt, exp_gnt);
        end
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then
    // check at the next falling edge.
    task automatic applyStimulus(input logic [7:0] r, input logic d, input string tag);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        modelStep(r, d);
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        logic [7:0] r;
        logic       d;

        rst_n    = 1'b0;
        bus.req  = 8'h00;
        bus.done = 1'b0;
        modelReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset");
        checkGnt("reset_const", 8'h00);
        rst_n = 1'b1;

        repeat (5) applyStimulus(8'h00, 1'b0, "idle_zero");

        applyStimulus(8'hA4, 1'b0, "grant_a4");
        checkGnt("grant_a4_const", 8'h04);
        applyStimulus(8'hA4, 1'b0, "hold_a4");
        checkGnt("hold_a4_const", 8'h04);
        applyStimulus(8'hA4, 1'b1, "release_2");
        checkGnt("bubble_2_const", 8'h00);
        applyStimulus(8'hA4, 1'b0, "grant_5");
        checkGnt("grant_5_const", 8'h20);
        applyStimulus(8'hA4, 1'b1, "release_5");
        applyStimulus(8'hA4, 1'b0, "grant_7");
        checkGnt("grant_7_const", 8'h80);

        applyStimulus(8'h81, 1'b1, "release_7");
        checkGnt("bubble_7_const", 8'h00);
        applyStimulus(8'h81, 1'b0, "wrap_grant_0");
        checkGnt("wrap_grant_0_const", 8'h01);
        applyStimulus(8'h00, 1'b0, "withdraw_0");
        applyStimulus(8'h00, 1'b1, "done_in_idle");

        applyStimulus(8'h08, 1'b0, "grant_3");
        checkGnt("grant_3_const", 8'h08);
        applyStimulus(8'h00, 1'b0, "withdraw_3");
        checkGnt("withdraw_3_const", 8'h00);
        applyStimulus(8'h18, 1'b0, "ptr_after_withdraw");
        checkGnt("ptr_after_withdraw_const", 8'h10);
        applyStimulus(8'h18, 1'b0, "hold_4");

        #2;
        rst_n   = 1'b0;
        bus.req = 8'hFF;
        #1;
        modelReset();
        checkGnt("async_reset_const", 8'h00);
        checkOutput("async_reset");
        @(negedge clk);
        checkOutput("reset_held");
        rst_n = 1'b1;
        applyStimulus(8'hFF, 1'b0, "after_reset");
        checkGnt("after_reset_const", 8'h01);

        applyStimulus(8'h00, 1'b0, "withdraw_before_hold");
        for (int i = 1; i <= 12; i++) begin
            applyStimulus(8'h02, 1'b0, "long_hold");
`ifdef RR_ARB_TIMEOUT_EN
            checkGnt("long_hold_const", ((i % 5) == 0) ? 8'h00 : 8'h02);
`else
            checkGnt("long_hold_const", 8'h02);
`endif
        end
        applyStimulus(8'h00, 1'b0, "withdraw_after_hold");

        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 4) == 0) begin
                r = 8'($urandom);
            end
            d = (($urandom % 5) == 0);
            applyStimulus(r, d, "random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
